// File: rtl/float_division_if.sv
// Start/done handshake and operand/result bus of the single-precision divider.
//   master : issue side, drives start/A/B and observes result and status
//   slave  : divider side
interface float_division_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] result;
    logic            busy;
    logic            done;
    logic            overflow;
    logic            underflow;
    logic            div_by_zero;
    logic            invalid;

    modport master (
        output start, A, B,
        input  result, busy, done, overflow, underflow, div_by_zero, invalid
    );

    modport slave (
        input  start, A, B,
        output result, busy, done, overflow, underflow, div_by_zero, invalid
    );
endinterface

// File: rtl/float_division.sv
// Iterative IEEE-754 binary32 divider: one restoring quotient bit per clock,
// round-to-nearest-even, subnormals flushed to zero. Fixed 28-cycle latency.
//   clk, rst : clock and synchronous active-high reset
//   bus      : start/A/B in; result, busy, done pulse and exception flags out
module float_division #(
    parameter int unsigned XLEN = 32
) (
    input logic            clk,
    input logic            rst,
    float_division_if.slave bus
);
    localparam int unsigned MW = 24;   // significand including hidden bit
    localparam int unsigned QW = 26;   // quotient bits produced
    localparam int unsigned RW = 26;   // remainder width (holds 2*divisor)
    localparam int unsigned EW = 10;   // signed working exponent
    localparam logic [4:0]  LAST_ITER = 5'd25;

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    state_t          state, state_next;
    special_t        special, special_in;
    logic            dbz_pend, dbz_in;
    logic            sign;
    logic [7:0]      exp_a, exp_b;
    logic [MW-1:0]   divisor;
    logic [RW-1:0]   rem, rem_next;
    logic [QW-1:0]   quo;
    logic [4:0]      iter;
    logic            ge;

    logic            a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [MW-1:0]   mant;
    logic            guard, sticky, inc;
    logic [MW:0]     mant_sum;
    logic [MW-2:0]   frac_c;
    logic [EW-1:0]   exp_pre, exp_c;
    logic            ovf_c, unf_c, dbz_c, inv_c;
    logic [XLEN-1:0] res_c;

    // Operand classification; exp=0 counts as zero whatever the fraction.
    always_comb begin
        a_zero     = bus.A[30:23] == 8'd0;
        b_zero     = bus.B[30:23] == 8'd0;
        a_inf      = (bus.A[30:23] == 8'hFF) && (bus.A[22:0] == 23'd0);
        b_inf      = (bus.B[30:23] == 8'hFF) && (bus.B[22:0] == 23'd0);
        a_nan      = (bus.A[30:23] == 8'hFF) && (bus.A[22:0] != 23'd0);
        b_nan      = (bus.B[30:23] == 8'hFF) && (bus.B[22:0] != 23'd0);
        special_in = SP_NONE;
        dbz_in     = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_in = SP_NAN;
        end else if (a_inf) begin
            special_in = SP_INF;
        end else if (b_zero) begin
            special_in = SP_INF;
            dbz_in     = 1'b1;
        end else if (b_inf || a_zero) begin
            special_in = SP_ZERO;
        end
    end

    // One restoring step: compare, conditionally subtract, shift for next bit.
    always_comb begin
        ge       = rem >= RW'(divisor);
        rem_next = ge ? ((rem - RW'(divisor)) << 1) : (rem << 1);
    end

    // Normalise, round to nearest even, range check and special override.
    always_comb begin
        if (quo[QW-1]) begin
            mant    = quo[QW-1:2];
            guard   = quo[1];
            sticky  = quo[0] | (|rem);
            exp_pre = EW'(exp_a) - EW'(exp_b) + EW'(127);
        end else begin
            mant    = quo[QW-2:1];
            guard   = quo[0];
            sticky  = |rem;
            exp_pre = EW'(exp_a) - EW'(exp_b) + EW'(126);
        end
        inc      = guard & (sticky | mant[0]);
        mant_sum = (MW+1)'(mant) + (MW+1)'(inc);
        if (mant_sum[MW]) begin
            frac_c = mant_sum[MW-1:1];
            exp_c  = exp_pre + EW'(1);
        end else begin
            frac_c = mant_sum[MW-2:0];
            exp_c  = exp_pre;
        end
        ovf_c = $signed(exp_c) >= $signed(EW'(255));
        unf_c = $signed(exp_c) <= $signed(EW'(0));
        dbz_c = 1'b0;
        inv_c = 1'b0;
        case (special)
            SP_NAN: begin
                res_c = 32'h7FC0_0000;
                inv_c = 1'b1;
                ovf_c = 1'b0;
                unf_c = 1'b0;
            end
            SP_INF: begin
                res_c = {sign, 8'hFF, 23'd0};
                dbz_c = dbz_pend;
                ovf_c = 1'b0;
                unf_c = 1'b0;
            end
            SP_ZERO: begin
                res_c = {sign, 31'd0};
                ovf_c = 1'b0;
                unf_c = 1'b0;
            end
            default: begin
                if (ovf_c) begin
                    res_c = {sign, 8'hFF, 23'd0};
                    unf_c = 1'b0;
                end else if (unf_c) begin
                    res_c = {sign, 31'd0};
                end else begin
                    res_c = {sign, exp_c[7:0], frac_c};
                end
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = DIVIDE;
            DIVIDE:  if (iter == LAST_ITER) state_next = ROUND;
            ROUND:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result      <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.underflow   <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.invalid     <= 1'b0;
            special         <= SP_NONE;
            dbz_pend        <= 1'b0;
            sign            <= 1'b0;
            exp_a           <= '0;
            exp_b           <= '0;
            divisor         <= '0;
            rem             <= '0;
            quo             <= '0;
            iter            <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    if (bus.start) begin
                        sign            <= bus.A[31] ^ bus.B[31];
                        exp_a           <= bus.A[30:23];
                        exp_b           <= bus.B[30:23];
                        rem             <= RW'({1'b1, bus.A[22:0]});
                        divisor         <= {1'b1, bus.B[22:0]};
                        quo             <= '0;
                        iter            <= '0;
                        special         <= special_in;
                        dbz_pend        <= dbz_in;
                        bus.busy        <= 1'b1;
                        bus.overflow    <= 1'b0;
                        bus.underflow   <= 1'b0;
                        bus.div_by_zero <= 1'b0;
                        bus.invalid     <= 1'b0;
                    end
                end
                DIVIDE: begin
                    quo  <= {quo[QW-2:0], ge};
                    rem  <= rem_next;
                    iter <= iter + 5'd1;
                end
                ROUND: begin
                    bus.result      <= res_c;
                    bus.overflow    <= ovf_c;
                    bus.underflow   <= unf_c;
                    bus.div_by_zero <= dbz_c;
                    bus.invalid     <= inv_c;
                    bus.busy        <= 1'b0;
                    bus.done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_float_division.sv
// Bench for float_division: directed vectors, handshake corner cases and
// randomized operands checked against an exact integer division model.
module tb_float_division;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    float_division_if #(.XLEN(32)) bus();
    float_division #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Exact quotient of significands, rounded to nearest even by comparing
    // twice the remainder with the divisor. flags = {ovf, unf, dbz, inv}.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
        int     ea, eb, e, s;
        longint ma, mb, m, rm;
        logic   sg;
        bit     az, bz, ai, bi, an, bn;
        sg = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        f = 4'b0000;
        if (an || bn || (az && bz) || (ai && bi)) begin
            r = 32'h7FC0_0000; f = 4'b0001; return;
        end
        if (ai) begin r = {sg, 8'hFF, 23'd0}; return; end
        if (bz) begin r = {sg, 8'hFF, 23'd0}; f = 4'b0010; return; end
        if (bi || az) begin r = {sg, 31'd0}; return; end
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        if (ma >= mb) begin s = 23; e = ea - eb + 127; end
        else          begin s = 24; e = ea - eb + 126; end
        m  = (ma << s) / mb;
        rm = (ma << s) % mb;
        if ((2 * rm > mb) || ((2 * rm == mb) && (m % 2 == 1))) m = m + 1;
        if (m == (longint'(1) << 24)) begin m = m >> 1; e = e + 1; end
        if (e >= 255)    begin r = {sg, 8'hFF, 23'd0}; f = 4'b1000; end
        else if (e <= 0) begin r = {sg, 31'd0};        f = 4'b0100; end
        else             r = {sg, 8'(e), 23'(m)};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3, 4, 5: ;
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Issue one operation from the current negedge; lat counts cycles to done.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bus.result, bus.busy, bus.done, bus.overflow, bus.underflow,
             bus.div_by_zero, bus.invalid} !== 38'd0)
            $display("FAIL reset_outputs result=%h busy=%b done=%b got_flags=%b%b%b%b want all zero",
                     bus.result, bus.busy, bus.done, bus.overflow, bus.underflow,
                     bus.div_by_zero, bus.invalid);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] ta[5] = '{32'h40C0_0000, 32'h3F80_0000, 32'h0000_0000, 32'h7F00_0000, 32'h0080_0000};
        logic [31:0] tb[5] = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h3E80_0000, 32'h7F00_0000};
        logic [31:0] tr[5] = '{32'h4040_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000};
        logic [3:0]  tf[5] = '{4'b0000, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], lat);
            total_cnt++;
            if (lat !== 28) $display("FAIL dir%0d_latency got=%0d want=28", i, lat);
            else pass_cnt++;
            total_cnt++;
            if (bus.busy !== 1'b0) $display("FAIL dir%0d_busy_at_done got=%b want=0", i, bus.busy);
            else pass_cnt++;
            total_cnt++;
            if (bus.result !== tr[i]) $display("FAIL dir%0d_result got=%h want=%h", i, bus.result, tr[i]);
            else pass_cnt++;
            total_cnt++;
            if ({bus.overflow, bus.underflow, bus.div_by_zero, bus.invalid} !== tf[i])
                $display("FAIL dir%0d_flags got=%b%b%b%b want=%b", i, bus.overflow, bus.underflow,
                         bus.div_by_zero, bus.invalid, tf[i]);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (bus.done !== 1'b0 || bus.result !== tr[i])
                $display("FAIL dir%0d_hold done=%b result=%h want done=0 result=%h", i, bus.done, bus.result, tr[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(32'h3F80_0000, 32'h4040_0000, lat);
        total_cnt++;
        if (lat !== 28 || bus.result !== 32'h3EAA_AAAB)
            $display("FAIL b2b_first got lat=%0d result=%h want lat=28 result=3eaaaaab", lat, bus.result);
        else pass_cnt++;
        do_op(32'hC0CC_CCCD, 32'hBF00_0000, lat);
        total_cnt++;
        if (lat !== 28 || bus.result !== 32'h414C_CCCD)
            $display("FAIL b2b_second got lat=%0d result=%h want lat=28 result=414ccccd", lat, bus.result);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int lat, extra;
        bus.start = 1'b1;
        bus.A = 32'h3F80_0000;
        bus.B = 32'h4040_0000;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (lat < 5) begin @(negedge clk); lat++; end
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL ign_busy got=%b want=1", bus.busy);
        else pass_cnt++;
        bus.start = 1'b1;
        bus.A = 32'h40C0_0000;
        bus.B = 32'h4000_0000;
        @(negedge clk);
        lat++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        total_cnt++;
        if (lat !== 28 || bus.result !== 32'h3EAA_AAAB)
            $display("FAIL ign_result got lat=%0d result=%h want lat=28 result=3eaaaaab", lat, bus.result);
        else pass_cnt++;
        extra = 0;
        repeat (35) begin @(negedge clk); if (bus.done === 1'b1) extra++; end
        total_cnt++;
        if (extra !== 0) $display("FAIL ign_extra_done got=%0d want=0", extra);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, dones;
        do_op(32'h40C0_0000, 32'h4000_0000, lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 32'h3F80_0000;
        bus.B = 32'h4040_0000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.result !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL rst_mid got result=%h busy=%b done=%b want 0/0/0", bus.result, bus.busy, bus.done);
        else pass_cnt++;
        rst = 1'b0;
        dones = 0;
        repeat (40) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
        total_cnt++;
        if (dones !== 0) $display("FAIL rst_mid_no_done got=%0d want=0", dones);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, er;
        logic [3:0]  ef;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = rand_op();
            b = rand_op();
            ref_div(a, b, er, ef);
            do_op(a, b, lat);
            total_cnt++;
            if (lat !== 28 || bus.result !== er)
                $display("FAIL rand%0d_result a=%h b=%h got lat=%0d result=%h want lat=28 result=%h",
                         i, a, b, lat, bus.result, er);
            else pass_cnt++;
            total_cnt++;
            if ({bus.overflow, bus.underflow, bus.div_by_zero, bus.invalid} !== ef)
                $display("FAIL rand%0d_flags a=%h b=%h got=%b%b%b%b want=%b", i, a, b,
                         bus.overflow, bus.underflow, bus.div_by_zero, bus.invalid, ef);
            else pass_cnt++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
